// File: rtl/writeback_arbiter.sv
// Register-bank writeback arbiter: two one-entry holding slots (ALU, load) committed round-robin onto one write port.
// Latency: a result handshaken at edge N drives write_en during cycle N..N+1 and is committed by the bank at edge N+1.
// Backpressure: x_ready = !x_full || x_granted (registered state only); a stalled slot holds until granted or reset.
// Optional feature macro: WB_BYPASS_EN (same-cycle forwarding of the committing value to the three read ports).

module writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_sync,

  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [IDX_W-1:0]     alu_index,
  input  logic [DATA_W-1:0]    alu_data,

  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [IDX_W-1:0]     mem_index,
  input  logic [DATA_W-1:0]    mem_data,

  output logic                 write_en,
  output logic [IDX_W-1:0]     write_index,
  output logic [DATA_W-1:0]    write,

  output logic [(1<<IDX_W)-1:0] pending,

  input  logic [IDX_W-1:0]     read_a_index,
  input  logic [IDX_W-1:0]     read_b_index,
  input  logic [IDX_W-1:0]     read_c_index,
  output logic                 fwd_a_hit,
  output logic                 fwd_b_hit,
  output logic                 fwd_c_hit,
  output logic [DATA_W-1:0]    fwd_a,
  output logic [DATA_W-1:0]    fwd_b,
  output logic [DATA_W-1:0]    fwd_c
);

  localparam int NREG = 1 << IDX_W;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // Holding slots and round-robin pointer
  logic              alu_full_q, alu_full_d;
  logic [IDX_W-1:0]  alu_idx_q,  alu_idx_d;
  logic [DATA_W-1:0] alu_dat_q,  alu_dat_d;
  logic              mem_full_q, mem_full_d;
  logic [IDX_W-1:0]  mem_idx_q,  mem_idx_d;
  logic [DATA_W-1:0] mem_dat_q,  mem_dat_d;
  src_e              last_grant_q, last_grant_d;

  logic grant_alu;
  logic grant_mem;
  logic grant_valid;
  logic alu_hs;
  logic mem_hs;

  // Grant selection; nothing is granted during reset so held results are dropped without a write
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (!rst_sync) begin
      if (alu_full_q && mem_full_q) begin
        if (last_grant_q == SRC_MEM) begin
          grant_alu = 1'b1;
        end else begin
          grant_mem = 1'b1;
        end
      end else begin
        grant_alu = alu_full_q;
        grant_mem = mem_full_q;
      end
    end
  end

  assign grant_valid = grant_alu || grant_mem;

  // A slot can take a new result when empty or when it is draining this cycle
  assign alu_ready = rst_sync || !alu_full_q || grant_alu;
  assign mem_ready = rst_sync || !mem_full_q || grant_mem;
  assign alu_hs    = alu_valid && alu_ready;
  assign mem_hs    = mem_valid && mem_ready;

  // Write-port mux; index 0 consumes a grant but never raises write_en
  always_comb begin
    write_index = '0;
    write       = '0;
    if (grant_alu) begin
      write_index = alu_idx_q;
      write       = alu_dat_q;
    end else if (grant_mem) begin
      write_index = mem_idx_q;
      write       = mem_dat_q;
    end
    write_en = grant_valid && (write_index != '0);
  end

  // Pending-write mask for issue hazard checks; r0 is never reported
  always_comb begin
    pending = '0;
    for (int i = 1; i < NREG; i++) begin
      pending[i] = (alu_full_q && (alu_idx_q == IDX_W'(i))) ||
                   (mem_full_q && (mem_idx_q == IDX_W'(i)));
    end
  end

  // Slot and pointer next state: a same-edge handshake refills a draining slot
  always_comb begin
    alu_full_d   = alu_full_q && !grant_alu;
    alu_idx_d    = alu_idx_q;
    alu_dat_d    = alu_dat_q;
    mem_full_d   = mem_full_q && !grant_mem;
    mem_idx_d    = mem_idx_q;
    mem_dat_d    = mem_dat_q;
    last_grant_d = last_grant_q;
    if (alu_hs) begin
      alu_full_d = 1'b1;
      alu_idx_d  = alu_index;
      alu_dat_d  = alu_data;
    end
    if (mem_hs) begin
      mem_full_d = 1'b1;
      mem_idx_d  = mem_index;
      mem_dat_d  = mem_data;
    end
    if (grant_alu) begin
      last_grant_d = SRC_ALU;
    end else if (grant_mem) begin
      last_grant_d = SRC_MEM;
    end
  end

  // State registers; reset empties both slots and lets the ALU win the first tie
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      alu_full_q   <= 1'b0;
      alu_idx_q    <= '0;
      alu_dat_q    <= '0;
      mem_full_q   <= 1'b0;
      mem_idx_q    <= '0;
      mem_dat_q    <= '0;
      last_grant_q <= SRC_MEM;
    end else begin
      alu_full_q   <= alu_full_d;
      alu_idx_q    <= alu_idx_d;
      alu_dat_q    <= alu_dat_d;
      mem_full_q   <= mem_full_d;
      mem_idx_q    <= mem_idx_d;
      mem_dat_q    <= mem_dat_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef WB_BYPASS_EN
  // Same-cycle forwarding of the value being committed; write_en already excludes r0
  always_comb begin
    fwd_a_hit = write_en && (write_index == read_a_index);
    fwd_b_hit = write_en && (write_index == read_b_index);
    fwd_c_hit = write_en && (write_index == read_c_index);
    fwd_a     = fwd_a_hit ? write : '0;
    fwd_b     = fwd_b_hit ? write : '0;
    fwd_c     = fwd_c_hit ? write : '0;
  end
`else
  logic unused_read_idx;
  assign unused_read_idx = ^{read_a_index, read_b_index, read_c_index};

  // Forwarding disabled: outputs stay present but are tied off
  always_comb begin
    fwd_a_hit = 1'b0;
    fwd_b_hit = 1'b0;
    fwd_c_hit = 1'b0;
    fwd_a     = '0;
    fwd_b     = '0;
    fwd_c     = '0;
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios followed by randomized traffic.
// Every cycle the outputs are compared with a slot-level reference model of the arbitration rules.
// Producers obey the hold-until-ready protocol; resets are injected randomly during the random phase.

module tb_writeback_arbiter;

  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_sync;
  logic          alu_valid, mem_valid;
  logic          alu_ready, mem_ready;
  logic [IW-1:0] alu_index, mem_index;
  logic [DW-1:0] alu_data, mem_data;
  logic          write_en;
  logic [IW-1:0] write_index;
  logic [DW-1:0] write;
  logic [15:0]   pending;
  logic [IW-1:0] read_a_index, read_b_index, read_c_index;
  logic          fwd_a_hit, fwd_b_hit, fwd_c_hit;
  logic [DW-1:0] fwd_a, fwd_b, fwd_c;

  writeback_arbiter #(.DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst_sync(rst_sync),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_index(alu_index), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_index(mem_index), .mem_data(mem_data),
    .write_en(write_en), .write_index(write_index), .write(write), .pending(pending),
    .read_a_index(read_a_index), .read_b_index(read_b_index), .read_c_index(read_c_index),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit), .fwd_c_hit(fwd_c_hit),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c)
  );

  always #5 clk = ~clk;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: port 0 = ALU, port 1 = mem; each port holds at most one result
  bit            m_full [2];
  logic [IW-1:0] m_idx  [2];
  logic [DW-1:0] m_dat  [2];
  int            m_last;
  bit            acc_alu, acc_mem, rst_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (rst_sync) return -1;
    if (m_full[0] && m_full[1]) return (m_last == 1) ? 0 : 1;
    if (m_full[0]) return 0;
    if (m_full[1]) return 1;
    return -1;
  endfunction

  function automatic logic [DW-1:0] fwd_exp(input bit we, input logic [IW-1:0] wi,
                                             input logic [DW-1:0] wd, input logic [IW-1:0] ri);
    return (BYPASS && we && wi == ri) ? wd : '0;
  endfunction

  // Compare every output with the model, clock once, advance the model, return at the negedge
  task automatic step();
    int g;
    bit e_we, e_ra, e_rm;
    logic [IW-1:0] e_wi;
    logic [DW-1:0] e_wd;
    logic [15:0] e_pend;
    #1;
    g    = model_grant();
    e_wi = (g >= 0) ? m_idx[g] : '0;
    e_wd = (g >= 0) ? m_dat[g] : '0;
    e_we = (g >= 0) && (e_wi != 0);
    e_ra = rst_sync || !m_full[0] || (g == 0);
    e_rm = rst_sync || !m_full[1] || (g == 1);
    e_pend = '0;
    for (int i = 1; i < 16; i++)
      e_pend[i] = (m_full[0] && m_idx[0] == IW'(i)) || (m_full[1] && m_idx[1] == IW'(i));
    chk("write_en",    {31'b0, write_en},  {31'b0, e_we});
    chk("write_index", {28'b0, write_index}, {28'b0, e_wi});
    chk("write",       write, e_wd);
    chk("alu_ready",   {31'b0, alu_ready}, {31'b0, e_ra});
    chk("mem_ready",   {31'b0, mem_ready}, {31'b0, e_rm});
    chk("pending",     {16'b0, pending},   {16'b0, e_pend});
    chk("fwd_a_hit",   {31'b0, fwd_a_hit}, {31'b0, BYPASS && e_we && e_wi == read_a_index});
    chk("fwd_b_hit",   {31'b0, fwd_b_hit}, {31'b0, BYPASS && e_we && e_wi == read_b_index});
    chk("fwd_c_hit",   {31'b0, fwd_c_hit}, {31'b0, BYPASS && e_we && e_wi == read_c_index});
    chk("fwd_a",       fwd_a, fwd_exp(e_we, e_wi, e_wd, read_a_index));
    chk("fwd_b",       fwd_b, fwd_exp(e_we, e_wi, e_wd, read_b_index));
    chk("fwd_c",       fwd_c, fwd_exp(e_we, e_wi, e_wd, read_c_index));
    @(posedge clk);
    rst_seen = rst_sync;
    acc_alu  = !rst_sync && alu_valid && e_ra;
    acc_mem  = !rst_sync && mem_valid && e_rm;
    if (rst_sync) begin
      m_full[0] = 0; m_full[1] = 0; m_last = 1;
    end else begin
      if (g >= 0) begin m_full[g] = 0; m_last = g; end
      if (acc_alu) begin m_full[0] = 1; m_idx[0] = alu_index; m_dat[0] = alu_data; end
      if (acc_mem) begin m_full[1] = 1; m_idx[1] = mem_index; m_dat[1] = mem_data; end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_sync = 1'b1;
    step();
    rst_sync = 1'b0;
  endtask

  initial begin
    int n_alu, n_mem;
    rst_sync = 1'b1;
    alu_valid = 0; alu_index = '0; alu_data = '0;
    mem_valid = 0; mem_index = '0; mem_data = '0;
    read_a_index = '0; read_b_index = '0; read_c_index = '0;
    m_full[0] = 0; m_full[1] = 0; m_idx[0] = '0; m_idx[1] = '0;
    m_dat[0] = '0; m_dat[1] = '0; m_last = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst_sync = 1'b0;

    // Reset state and a single ALU result to r3
    step();
    alu_valid = 1; alu_index = 4'd3; alu_data = 32'h0000_00AA;
    step();
    alu_valid = 0;
    #1;
    chk("t1_we", {31'b0, write_en}, 32'd1);
    chk("t1_idx", {28'b0, write_index}, 32'd3);
    chk("t1_data", write, 32'hAA);
    chk("t1_pend3", {31'b0, pending[3]}, 32'd1);
    step();
    #1;
    chk("t1_pend_clear", {16'b0, pending}, 32'd0);
    step();

    // Simultaneous offers after reset: ALU wins the first tie
    do_reset();
    alu_valid = 1; alu_index = 4'd1; alu_data = 32'h11;
    mem_valid = 1; mem_index = 4'd2; mem_data = 32'h22;
    step();
    alu_valid = 0; mem_valid = 0;
    #1;
    chk("t2_first", {28'b0, write_index}, 32'd1);
    step();
    #1;
    chk("t2_second", {28'b0, write_index}, 32'd2);
    chk("t2_second_data", write, 32'h22);
    step();

    // Both ports saturated: commits alternate, 4 each over 8 cycles
    alu_valid = 1; alu_index = 4'd1; alu_data = 32'h100;
    mem_valid = 1; mem_index = 4'd2; mem_data = 32'h200;
    n_alu = 0; n_mem = 0;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) begin
        #1;
        if (write_en && write_index == 4'd1) n_alu++;
        if (write_en && write_index == 4'd2) n_mem++;
      end
      step();
      if (acc_alu) alu_data = alu_data + 1;
      if (acc_mem) mem_data = mem_data + 1;
    end
    alu_valid = 0; mem_valid = 0;
    chk("t3_alu_commits", n_alu, 32'd4);
    chk("t3_mem_commits", n_mem, 32'd4);
    repeat (3) step();

    // Load to r0 retires silently, following ALU result commits next
    mem_valid = 1; mem_index = 4'd0; mem_data = 32'hDEAD;
    step();
    mem_valid = 0;
    alu_valid = 1; alu_index = 4'd5; alu_data = 32'h55;
    #1;
    chk("t4_r0_we", {31'b0, write_en}, 32'd0);
    chk("t4_r0_pend", {16'b0, pending}, 32'd0);
    step();
    alu_valid = 0;
    #1;
    chk("t4_r5_we", {31'b0, write_en}, 32'd1);
    chk("t4_r5_idx", {28'b0, write_index}, 32'd5);
    chk("t4_r5_data", write, 32'h55);
    step();

    // Reset with both slots full discards them
    alu_valid = 1; alu_index = 4'd4; alu_data = 32'h44;
    mem_valid = 1; mem_index = 4'd6; mem_data = 32'h66;
    step();
    alu_valid = 0; mem_valid = 0;
    rst_sync = 1;
    #1;
    chk("t5_we_in_rst", {31'b0, write_en}, 32'd0);
    step();
    rst_sync = 0;
    #1;
    chk("t5_we_after", {31'b0, write_en}, 32'd0);
    chk("t5_pend", {16'b0, pending}, 32'd0);
    chk("t5_ready", {30'b0, alu_ready, mem_ready}, 32'd3);
    step();
    alu_valid = 1; alu_index = 4'd7; alu_data = 32'h77;
    step();
    alu_valid = 0;
    #1;
    chk("t5_r7_idx", {28'b0, write_index}, 32'd7);
    chk("t5_r7_data", write, 32'h77);
    step();

    // Bypass on read port b while r9 commits
    alu_valid = 1; alu_index = 4'd9; alu_data = 32'h1234;
    step();
    alu_valid = 0;
    read_a_index = 4'd8; read_b_index = 4'd9;
    #1;
    chk("t6_fwd_b_hit", {31'b0, fwd_b_hit}, {31'b0, BYPASS});
    chk("t6_fwd_b", fwd_b, BYPASS ? 32'h1234 : 32'h0);
    chk("t6_fwd_a_hit", {31'b0, fwd_a_hit}, 32'd0);
    step();

    // Random traffic with hold-until-ready producers and occasional resets
    for (int c = 0; c < 600; c++) begin
      if (!alu_valid && $urandom_range(0, 2) != 0) begin
        alu_valid = 1; alu_index = IW'($urandom_range(0, 15)); alu_data = $urandom;
      end
      if (!mem_valid && $urandom_range(0, 2) != 0) begin
        mem_valid = 1; mem_index = IW'($urandom_range(0, 15)); mem_data = $urandom;
      end
      rst_sync = ($urandom_range(0, 49) == 0);
      read_a_index = IW'($urandom_range(0, 15));
      read_b_index = IW'($urandom_range(0, 15));
      read_c_index = IW'($urandom_range(0, 15));
      step();
      if (acc_alu || rst_seen) alu_valid = 0;
      if (acc_mem || rst_seen) mem_valid = 0;
    end
    rst_sync = 0;
    alu_valid = 0; mem_valid = 0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Drives the single write port of the 16×32 register bank from two result producers: the ALU and the memory/load unit. Each producer hands results over on a valid/ready handshake into a one-entry holding slot. A round-robin arbiter commits one slot per cycle onto write_en/write_index/write. The block also exports a pending-write mask for issue-stage hazard checks, and optionally a same-cycle bypass for the bank's three read ports.

## Interface
- DATA_W, 32, result/register width
- IDX_W, 4, register index width (bank depth 2**IDX_W)
- clk  in  1  clock; all state on rising edge
- rst_sync  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU slot can accept
- alu_index  in  IDX_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  mem slot can accept
- mem_index  in  IDX_W  load destination register
- mem_data  in  DATA_W  load result
- write_en  out  1  to bank write_en
- write_index  out  IDX_W  to bank write_index
- write  out  DATA_W  to bank write data
- pending  out  2**IDX_W  bit i set while a write to ri is held; bit 0 always 0
- read_a_index, read_b_index, read_c_index  in  IDX_W each  indices the bank is reading this cycle (bypass)
- fwd_a_hit, fwd_b_hit, fwd_c_hit  out  1 each  bypass hit
- fwd_a, fwd_b, fwd_c  out  DATA_W each  bypass data

## Operation
- Two holding slots, alu and mem, each holding full, index, and data.
- A handshake occurs on a rising edge with x_valid && x_ready. It loads index/data and sets full.
- Grant logic is combinational from slot state and last_grant:
  - only one slot full: grant it;
  - both full: grant the slot not granted last;
  - none full: no grant.
- The granted slot drives write_index and write.
- write_en = grant_valid && granted index != 0.
- A granted slot clears full at the edge, unless the same edge loads it with a new handshake.
- last_grant updates on every grant.
- x_ready = !x_full || x_granted. This depends only on registered state, so there is no valid-to-ready combinational path.
- Index-0 results are accepted and consume an arbitration slot. write_en stays 0 for them; they retire silently.
- pending[i] = OR over full slots whose index == i, for i != 0.
- Same index in both slots: commits occur in arbitration order and both commit. Preventing WAW hazards is issue logic's job, using pending.
- When neither slot is full, write_index and write are driven 0.

## Timing
- Reset values: both slots empty, last_grant = mem (so ALU wins the first tie), write_en 0, write_index 0, write 0, pending 0, alu_ready 1, mem_ready 1, all fwd_* 0.
- Latency: a handshake at edge N puts write_en high in cycle N..N+1. The bank commits at edge N+1. The value is readable from the bank in the following cycle.
- Throughput: one commit per cycle total. Each port sustains one per cycle when the other is idle, and one per two cycles when both are saturated.
- A stalled port holds its slot. The producer must hold valid/index/data until ready. ready never deasserts without a grant or reset.
- Reset mid-operation: held results are discarded, with no write_en in the reset cycle or the one after.

## Configuration
- WB_BYPASS_EN defined:
  - fwd_x_hit = write_en && write_index == read_x_index;
  - fwd_x = write when hit, else 0.
  - Index 0 never hits.
  - Consumers select fwd_x over the bank read_x.
- WB_BYPASS_EN undefined:
  - ports remain present;
  - all fwd_* are tied 0;
  - read_*_index are ignored.
  - Issue logic must stall one extra cycle on write-after-commit.

## Test plan
- Reset, then an ALU handshake with index 3, data 0x0000_00AA → next cycle: write_en=1, write_index=3, write=0xAA, pending[3]=1. The cycle after: pending=0, and the bank reads r3=0xAA.
- ALU (r1=0x11) and mem (r2=0x22) offered on the same edge → r1 commits first, then r2 on consecutive cycles. alu_ready and mem_ready never drop when valid is deasserted after the handshake.
- Both ports held continuously valid for 8 cycles → commits alternate alu/mem, 4 each. Each x_ready is high every other cycle. No result is lost or duplicated.
- Mem result to r0 (data 0xDEAD) → accepted, write_en=0 in its grant cycle, pending[0]=0. A following ALU result r5=0x55 commits next.
- rst_sync asserted while both slots are full (r4, r6) → no write_en afterwards, pending=0, both ready=1. A fresh r7=0x77 then commits normally.
- With WB_BYPASS_EN: commit r9=0x1234 with read_b_index=9 and read_a_index=8 → fwd_b_hit=1 with fwd_b=0x1234, fwd_a_hit=0. Without the macro, all fwd_* = 0.
